// File: rtl/game_controller.sv
// Flappy-bird game sequencer: button conditioning, one-hot game state machine,
// per-frame bird physics with ceiling/floor handling, and the pipe score counter.
module game_controller #(
  parameter int START_Y     = 200,
  parameter int FLOOR_Y     = 378,
  parameter int BIRD_SIZE_Y = 24,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = -8,
  parameter int MAX_FALL    = 10,
  parameter int END_HOLD    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        flap_btn,
  input  logic        pause_btn,
  input  logic        collision,
  input  logic        pipe_passed,
  output logic [3:0]  game_state,
  output logic [15:0] birdY,
  output logic        flap,
  output logic [15:0] score
);

  typedef enum logic [3:0] {
    ST_START = 4'b0001,
    ST_GAME  = 4'b0010,
    ST_PAUSE = 4'b0100,
    ST_END   = 4'b1000
  } state_t;

  localparam logic [15:0]        START_Y16  = 16'(START_Y);
  localparam logic [15:0]        FLOOR_Y16  = 16'(FLOOR_Y - BIRD_SIZE_Y);
  localparam logic signed [16:0] FLOOR_LIM  = 17'(FLOOR_Y - BIRD_SIZE_Y);
  localparam logic signed [10:0] GRAV11     = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF11     = 11'(MAX_FALL);
  localparam logic signed [9:0]  MAXF10     = 10'(MAX_FALL);
  localparam logic signed [9:0]  FLAPV10    = 10'(FLAP_VEL);
  localparam logic [15:0]        END_HOLD16 = 16'(END_HOLD);

  state_t             state_r, state_nxt_s;
  logic [15:0]        bird_y_r, bird_y_nxt_s;
  logic signed [9:0]  vel_r, vel_nxt_s;
  logic               flap_r, flap_nxt_s;
  logic [15:0]        score_r, score_nxt_s;
  logic               pend_r, pend_nxt_s;
  logic [15:0]        end_cnt_r, end_cnt_nxt_s;
  logic [1:0]         flap_sync_r, pause_sync_r;
  logic               flap_prev_r, pause_prev_r;

  logic               flap_rise_s, pause_rise_s;
  logic signed [10:0] vel_inc_s;
  logic signed [9:0]  vnew_s;
  logic signed [16:0] y_new_s;
  logic               floor_hit_s, end_hit_s;
  logic [15:0]        score_inc_s;

  assign flap_rise_s  = flap_sync_r[1] & ~flap_prev_r;
  assign pause_rise_s = pause_sync_r[1] & ~pause_prev_r;

  // Button synchronizers and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      flap_sync_r  <= 2'b00;
      pause_sync_r <= 2'b00;
      flap_prev_r  <= 1'b0;
      pause_prev_r <= 1'b0;
    end else begin
      flap_sync_r  <= {flap_sync_r[0], flap_btn};
      pause_sync_r <= {pause_sync_r[0], pause_btn};
      flap_prev_r  <= flap_sync_r[1];
      pause_prev_r <= pause_sync_r[1];
    end
  end

  // Physics step candidates; only committed in IN_GAME on a frame tick
  always_comb begin
    vel_inc_s = {vel_r[9], vel_r} + GRAV11;
    if (pend_r) begin
      vnew_s = FLAPV10;
    end else if (vel_inc_s > MAXF11) begin
      vnew_s = MAXF10;
    end else begin
      vnew_s = vel_inc_s[9:0];
    end
    y_new_s     = $signed({1'b0, bird_y_r}) + $signed({{7{vnew_s[9]}}, vnew_s});
    floor_hit_s = ~y_new_s[16] & (y_new_s >= FLOOR_LIM);
    end_hit_s   = frame_tick & (collision | floor_hit_s);
    score_inc_s = (score_r == 16'hFFFF) ? score_r : score_r + 16'd1;
  end

  // Next-state and datapath decode
  always_comb begin
    state_nxt_s   = state_r;
    bird_y_nxt_s  = bird_y_r;
    vel_nxt_s     = vel_r;
    flap_nxt_s    = 1'b0;
    score_nxt_s   = score_r;
    pend_nxt_s    = pend_r;
    end_cnt_nxt_s = end_cnt_r;
    case (state_r)
      ST_START: begin
        bird_y_nxt_s = START_Y16;
        vel_nxt_s    = 10'sd0;
        if (flap_rise_s) begin
          state_nxt_s = ST_GAME;
          score_nxt_s = 16'd0;
          pend_nxt_s  = 1'b1;  // first IN_GAME frame flaps
        end else begin
          pend_nxt_s  = 1'b0;
        end
      end
      ST_GAME: begin
        score_nxt_s = pipe_passed ? score_inc_s : score_r;
        if (frame_tick && !collision) begin
          vel_nxt_s  = vnew_s;
          flap_nxt_s = pend_r;
          if (y_new_s[16]) begin
            bird_y_nxt_s = 16'd0;
          end else if (floor_hit_s) begin
            bird_y_nxt_s = FLOOR_Y16;
          end else begin
            bird_y_nxt_s = y_new_s[15:0];
          end
        end else begin
          bird_y_nxt_s = bird_y_r;
        end
        if (end_hit_s) begin
          state_nxt_s = ST_END;
        end else if (pause_rise_s) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_GAME;
        end
        // A rise on the tick cycle is held over to the next frame
        if (end_hit_s || pause_rise_s) begin
          pend_nxt_s = 1'b0;
        end else if (flap_rise_s) begin
          pend_nxt_s = 1'b1;
        end else if (frame_tick) begin
          pend_nxt_s = 1'b0;
        end else begin
          pend_nxt_s = pend_r;
        end
      end
      ST_PAUSE: begin
        pend_nxt_s  = 1'b0;
        state_nxt_s = pause_rise_s ? ST_GAME : ST_PAUSE;
      end
      ST_END: begin
        pend_nxt_s = 1'b0;
        if (flap_rise_s && (end_cnt_r == END_HOLD16)) begin
          state_nxt_s   = ST_START;
          bird_y_nxt_s  = START_Y16;
          vel_nxt_s     = 10'sd0;
          end_cnt_nxt_s = 16'd0;
        end else if (frame_tick && (end_cnt_r < END_HOLD16)) begin
          end_cnt_nxt_s = end_cnt_r + 16'd1;
        end else begin
          end_cnt_nxt_s = end_cnt_r;
        end
      end
      default: begin
        state_nxt_s   = ST_START;
        bird_y_nxt_s  = START_Y16;
        vel_nxt_s     = 10'sd0;
        pend_nxt_s    = 1'b0;
        end_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_START;
      bird_y_r  <= START_Y16;
      vel_r     <= 10'sd0;
      flap_r    <= 1'b0;
      score_r   <= 16'd0;
      pend_r    <= 1'b0;
      end_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      bird_y_r  <= bird_y_nxt_s;
      vel_r     <= vel_nxt_s;
      flap_r    <= flap_nxt_s;
      score_r   <= score_nxt_s;
      pend_r    <= pend_nxt_s;
      end_cnt_r <= end_cnt_nxt_s;
    end
  end

  assign game_state = state_r;
  assign birdY      = bird_y_r;
  assign flap       = flap_r;
  assign score      = score_r;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: a per-edge behavioural model queues every
// expected output change; an independent monitor pops one entry per observed change.
module tb_game_controller;
  localparam int START_Y = 200;
  localparam int FLOOR_Y = 378;
  localparam int BIRD    = 24;
  localparam int GRAV    = 1;
  localparam int FLAPV   = -8;
  localparam int MAXF    = 10;
  localparam int HOLD    = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0, flap_btn = 1'b0, pause_btn = 1'b0;
  logic        collision = 1'b0, pipe_passed = 1'b0;
  logic [3:0]  game_state;
  logic [15:0] birdY, score;
  logic        flap;

  always #5 clk = ~clk;

  game_controller #(
    .START_Y(START_Y), .FLOOR_Y(FLOOR_Y), .BIRD_SIZE_Y(BIRD), .GRAVITY(GRAV),
    .FLAP_VEL(FLAPV), .MAX_FALL(MAXF), .END_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap_btn(flap_btn),
    .pause_btn(pause_btn), .collision(collision), .pipe_passed(pipe_passed),
    .game_state(game_state), .birdY(birdY), .flap(flap), .score(score)
  );

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [36:0] exp_q[$];

  // Reference model: 0=start 1=game 2=pause 3=end
  int m_st, m_y, m_vel, m_score, m_pend, m_cnt;
  bit m_flap;
  logic [36:0] m_last = '1;

  task automatic publish();
    logic [36:0] t;
    t = {4'(1 << m_st), 16'(m_y), 16'(m_score), m_flap};
    if (t !== m_last) begin
      exp_q.push_back(t);
      m_last = t;
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_y = START_Y; m_vel = 0; m_score = 0;
    m_pend = 0; m_cnt = 0; m_flap = 1'b0;
    publish();
  endtask

  task automatic model_edge(input bit fr, input bit co, input bit pi, input bit frs, input bit prs);
    int vn, yn;
    bit ending;
    int lim;
    lim = FLOOR_Y - BIRD;
    m_flap = 1'b0;
    case (m_st)
      0: begin
        m_y = START_Y; m_vel = 0;
        if (frs) begin m_st = 1; m_score = 0; m_pend = 1; end
      end
      1: begin
        ending = 1'b0;
        if (fr && co) ending = 1'b1;
        else if (fr) begin
          if (m_pend != 0) vn = FLAPV;
          else vn = (m_vel + GRAV > MAXF) ? MAXF : m_vel + GRAV;
          m_flap = (m_pend != 0);
          m_pend = 0;
          m_vel = vn;
          yn = m_y + vn;
          if (yn < 0) m_y = 0;
          else if (yn >= lim) begin m_y = lim; ending = 1'b1; end
          else m_y = yn;
        end
        if (pi && m_score < 65535) m_score++;
        if (frs) m_pend = 1;
        if (ending) begin m_st = 3; m_pend = 0; m_cnt = 0; end
        else if (prs) begin m_st = 2; m_pend = 0; end
      end
      2: if (prs) m_st = 1;
      3: begin
        if (frs && m_cnt == HOLD) begin m_st = 0; m_y = START_Y; m_vel = 0; m_cnt = 0; end
        else if (fr && m_cnt < HOLD) m_cnt++;
      end
      default: m_st = 0;
    endcase
    publish();
  endtask

  // One clock edge: drive inputs, predict, advance
  task automatic edge_cyc(input bit fr, input bit co, input bit pi, input bit frs, input bit prs);
    frame_tick = fr; collision = co; pipe_passed = pi;
    model_edge(fr, co, pi, frs, prs);
    @(posedge clk); #1;
    frame_tick = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
  endtask

  // Event whose button rise (if any) lands on the same edge as fr/co/pi
  task automatic ev(input bit fr, input bit co, input bit pi, input bit fl, input bit pa);
    if (fl || pa) begin
      flap_btn = fl; pause_btn = pa;
      edge_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      edge_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      edge_cyc(fr, co, pi, fl, pa);
      flap_btn = 1'b0; pause_btn = 1'b0;
      repeat (3) edge_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      edge_cyc(fr, co, pi, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every output change consumes one expected entry
  initial begin
    logic [36:0] cur, last, e;
    last = '1;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = {game_state, birdY, score, flap};
      if (cur !== last) begin
        last = cur;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change got state=%b y=%0d score=%0d flap=%b want no change",
                   cur[36:33], cur[32:17], cur[16:1], cur[0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL outputs got state=%b y=%0d score=%0d flap=%b want state=%b y=%0d score=%0d flap=%b",
                     cur[36:33], cur[32:17], cur[16:1], cur[0], e[36:33], e[32:17], e[16:1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // start, then free fall to the floor with some pipes
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (m_st != 1) break;
      ev(1'b1, 1'b0, (i % 3 == 0), 1'b0, 1'b0);
    end

    // end hold: early flap ignored, flap after the hold restarts
    repeat (30) ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // climb into the ceiling
    repeat (27) begin
      ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // pause freezes everything
    ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // collision beats pause; pipe still counts
    repeat (3) ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // mid-game reset
    repeat (60) ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();

    // randomized play
    repeat (400) begin
      r = $urandom_range(0, 11);
      case (r)
        0: ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        1: ev(1'b1, 1'b0, ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
        2: ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        3: ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        default: ev(1'b1, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      endcase
    end

    repeat (4) edge_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
